// File: rtl/seg7_pkg.sv
// Shared constants for the active-low seven-segment receive path:
// segment polarity, the legal glyph patterns and the scan FSM states.
package seg7_pkg;

  localparam logic SEG_ON  = 1'b0;
  localparam logic SEG_OFF = 1'b1;

  // Bit order 6..0 = middle, upper-left, lower-left, bottom,
  // lower-right, upper-right, top. A 0 bit lights its segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = {7{SEG_OFF}};

  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_t;

endpackage

// File: rtl/seg7_scan_rx_if.sv
// Frame output channel of the seven-segment receiver.
// Handshake: a frame moves on every rising clk edge where out_valid and
// out_ready are both 1. While out_valid is 1 and out_ready is 0 the source
// holds out_digits stable and keeps out_valid asserted; out_ready may be
// driven independently of out_valid.
interface seg7_scan_rx_if #(
  parameter int NUM_DIG = 4
) ();

  logic [4*NUM_DIG-1:0] out_digits;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_digits, output out_valid, input out_ready);
  modport slave  (input out_digits, input out_valid, output out_ready);

endinterface

// File: rtl/seg7_pat_decode.sv
// Combinational decode of one active-low segment pattern to a digit code.
// Anything other than 0-9 or fully blank is reported as illegal.
module seg7_pat_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] code
);

  // Exact-match lookup; illegal patterns report the blank code as filler.
  always_comb begin
    legal = 1'b1;
    code  = CODE_BLANK;
    case (seg)
      SEG_0:     code = 4'd0;
      SEG_1:     code = 4'd1;
      SEG_2:     code = 4'd2;
      SEG_3:     code = 4'd3;
      SEG_4:     code = 4'd4;
      SEG_5:     code = 4'd5;
      SEG_6:     code = 4'd6;
      SEG_7:     code = 4'd7;
      SEG_8:     code = 4'd8;
      SEG_9:     code = 4'd9;
      SEG_BLANK: code = CODE_BLANK;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Seven-segment scan receiver: samples the multiplexed segment bus, waits
// for each strobed pattern to hold for STABLE_CYC samples, decodes it into
// its digit slot and emits a full frame once every digit has been captured.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int NUM_DIG    = 4,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         seg_in,
  input  logic [NUM_DIG-1:0] dig_en_n,
  output logic [NUM_DIG-1:0] err,
  output scan_state_t        state,
  seg7_scan_rx_if.master     frm
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [6:0]           r_seg, p_seg;
  logic [NUM_DIG-1:0]   r_en, p_en;
  logic [CW-1:0]        cnt, cnt_nxt;
  scan_state_t          state_nxt;
  logic                 capture;
  logic                 one_cold;
  logic                 changed;
  logic                 dec_legal;
  logic [3:0]           dec_code;
  logic [4*NUM_DIG-1:0] slots;
  logic [NUM_DIG-1:0]   cap;
  logic                 frame_load;

  seg7_pat_decode u_dec (
    .seg   (r_seg),
    .legal (dec_legal),
    .code  (dec_code)
  );

  // Input sampling plus a one-cycle-old copy used for stability detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= SEG_BLANK;
      r_en  <= '1;
      p_seg <= SEG_BLANK;
      p_en  <= '1;
    end else begin
      r_seg <= seg_in;
      r_en  <= dig_en_n;
      p_seg <= r_seg;
      p_en  <= r_en;
    end
  end

  // Exactly one strobe low, and whether the sample moved since last cycle.
  always_comb begin
    one_cold = ($countones(~r_en) == 1);
    changed  = ({r_seg, r_en} != {p_seg, p_en});
  end

  // Scan FSM state and settle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: count identical samples, capture once when the count
  // reaches STABLE_CYC, then hold until the bus changes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (one_cold) begin
          state_nxt = SETTLE;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt = '0;
        end
      end
      SETTLE: begin
        if (!one_cold) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt = CNT_ONE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HOLD: begin
        if (changed) begin
          if (one_cold) begin
            state_nxt = SETTLE;
            cnt_nxt   = CNT_ONE;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    if (state_nxt == SETTLE && cnt_nxt == CNT_MAX) begin
      capture   = 1'b1;
      state_nxt = HOLD;
    end
  end

  // A frame loads from the slots once every digit is captured and the
  // output register is empty or being drained on this edge.
  always_comb begin
    frame_load = (&cap) && (!frm.out_valid || frm.out_ready);
  end

  // Slot capture, sticky error flags and the output frame register.
  // A capture on the same edge as a frame load keeps its cap bit, since
  // that value belongs to the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      slots          <= '0;
      cap            <= '0;
      err            <= '0;
      frm.out_digits <= '0;
      frm.out_valid  <= 1'b0;
    end else begin
      if (frame_load) begin
        frm.out_digits <= slots;
        frm.out_valid  <= 1'b1;
        cap            <= '0;
      end else if (frm.out_ready) begin
        frm.out_valid <= 1'b0;
      end
      for (int i = 0; i < NUM_DIG; i++) begin
        if (capture && !r_en[i]) begin
          if (dec_legal) begin
            slots[4*i +: 4] <= dec_code;
            cap[i]          <= 1'b1;
          end else begin
            err[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/seg7_scan_rx.md
# seg7_scan_rx

Receive-side block for the multiplexed active-low seven-segment bus. It samples the shared segment lines and digit strobes, waits for each strobed pattern to settle, and decodes it back to a 4-bit digit code. It assembles one code per digit position into a frame and hands the frame to downstream logic over a valid/ready handshake. It sits at the far end of the segment interface, for loopback checking of the display driver path and for reading external 7-segment sources.

## Interface
- NUM_DIG, 4, number of multiplexed digit positions (≥1)
- STABLE_CYC, 4, consecutive identical samples required before capture (≥1)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- seg_in  in  7  segment lines, active-low (0 = lit); bit0 = top, 1 = upper-right, 2 = lower-right, 3 = bottom, 4 = lower-left, 5 = upper-left, 6 = middle
- dig_en_n  in  NUM_DIG  digit strobes, active-low, one-cold when a digit is driven
- out_digits  out  4*NUM_DIG  frame, digit i at [4i+3:4i]; 0–9 or 4'hF (blank)
- out_valid  out  1  frame available
- out_ready  in  1  downstream accepts frame
- err  out  NUM_DIG  sticky per-digit illegal-pattern flag

## Operation
- seg_in and dig_en_n are registered once (r_seg, r_en). All decisions use the registered sample.
- Pattern legality: the only legal patterns (bits 6..0) are:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0011000
  - blank = 1111111 → 4'hF
  - Every other pattern is illegal.
- FSM, one instance shared across all digits:
  - IDLE: r_en is not one-cold (all high, or two or more low); cnt = 0. Go to SETTLE when r_en is one-cold.
  - SETTLE: each cycle, compare {r_seg, r_en} with the previous cycle.
    - Equal: cnt++.
    - Different: cnt = 1 (new pattern is still one-cold), or go to IDLE (not one-cold).
    - When cnt reaches STABLE_CYC, capture and go to HOLD.
  - HOLD: no further capture. Any change in {r_seg, r_en} goes to SETTLE with cnt = 1, or to IDLE if not one-cold.
- Capture at digit i:
  - Legal pattern: slot[i] ← code and cap[i] ← 1.
  - Illegal pattern: slot[i] is unchanged, cap[i] is unchanged, err[i] ← 1 (sticky until rst).
- Frame load: when all cap bits are 1 and (!out_valid || out_ready), then out_digits ← slots, out_valid ← 1, and all cap ← 0.
- Slot overwrite: a slot may be recaptured while cap is already set; the last capture wins.
- cnt width is $clog2(STABLE_CYC+1). cnt saturates and never wraps.

## Timing
- Reset values: out_digits = 0, out_valid = 0, err = 0, cap = 0, slots = 0, FSM = IDLE, cnt = 0.
- Capture latency: a legal pattern plus a one-cold strobe, applied before edge n and held, is registered at edge n and written to its slot at edge n+STABLE_CYC.
  - A shorter dwell produces no capture and no err.
- Frame latency: out_valid rises at the edge after the last cap bit sets, provided the output is free.
- Handshake:
  - Transfer occurs on an edge with out_valid && out_ready.
  - out_digits is stable while out_valid && !out_ready.
  - If a new frame is complete at the transfer edge, it loads on that same edge and out_valid stays 1.
  - Otherwise out_valid falls.
- Simultaneous cases:
  - A capture completing the frame on the same edge as a transfer: that capture lands in the slot, and the frame loads one edge later.
  - rst mid-frame: cap and partial slots are discarded, and any pending out_valid is dropped.

## Structure
- Package seg7_pkg:
  - SEG_ON = 1'b0, SEG_OFF = 1'b1
  - SEG_0..SEG_9 and SEG_BLANK 7-bit constants
  - CODE_BLANK = 4'hF
  - FSM state enum {IDLE, SETTLE, HOLD}
- Sub-module seg7_pat_decode: combinational, seg[6:0] → {legal, code[3:0]}. Also reusable by benches.

## Test plan
All scenarios use NUM_DIG = 4 and STABLE_CYC = 4.
1. After rst, drive 1111001 with dig_en_n = 1110 for 6 cycles → no out_valid. Then drive digits 1–3 with 0100100, 0110000, 0011001, 6 cycles each → out_digits = 16'h4321, out_valid = 1, err = 0.
2. Hold out_ready = 0 while scanning a second frame 9,8,7,blank → first frame stays on out_digits. Raise out_ready → next edge out_digits = 16'hF789.
3. Pattern 1111111 on dig 0 → code F accepted. Pattern 1010101 on dig 2 held 6 cycles → err = 4'b0100, slot 2 keeps its old value, no frame until a legal dig 2 arrives.
4. Dig 0 pattern held only 3 cycles, strobes cycling → no capture, cap[0] stays 0, no err.
5. dig_en_n = 1100 or 1111 for 10 cycles with any seg_in → FSM stays IDLE, no capture.
6. Assert rst after 3 of 4 digits are captured, then capture only dig 3 → no out_valid. All 4 digits are required again.
